// File: rtl/lc3b_types.sv
// Shared types for the LRU controller: per-set LRU word, way ID and controller state.
package lc3b_types;

    typedef logic [7:0] lc3b_lru;
    typedef logic [1:0] lc3b_way;

    // Reset order 3,2,1,0: way 3 is MRU, way 0 is the first victim.
    localparam lc3b_lru LRU_INIT = 8'hE4;

    typedef enum logic {
        INIT,
        RUN
    } lru_state_e;

endpackage

// File: rtl/LRU_stack.sv
// Move-to-front permutation of one 8-bit LRU word: the accessed way becomes MRU in [7:6],
// younger entries shift down one slot, older entries keep their position.
module LRU_stack
    import lc3b_types::*;
(
    input  lc3b_way way,
    input  lc3b_lru old_word,
    output lc3b_lru new_word
);

    always_comb begin
        // NOTE: default first so every path assigns new_word and no latch is inferred.
        new_word = old_word;
        if (old_word[1:0] == way) begin
            new_word = {way, old_word[7:2]};
        end else if (old_word[3:2] == way) begin
            new_word = {way, old_word[7:4], old_word[1:0]};
        end else if (old_word[5:4] == way) begin
            new_word = {way, old_word[7:6], old_word[3:0]};
        end
        // way already in [7:6]: word unchanged
    end

endmodule

// File: rtl/lru_controller.sv
// Per-set true-LRU tracker for a 4-way cache: INIT sweep, 2-stage update pipeline, victim query.
// Optional LRU_BYPASS_EN: forward the stage-1 word so same-set back-to-back updates never stall.
module lru_controller
    import lc3b_types::*;
#(
    parameter int SET_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_req,
    input  logic [SET_BITS-1:0] upd_set,
    input  logic [1:0]          upd_way,
    output logic                upd_ready,
    output logic                upd_ack,
    input  logic                vic_req,
    input  logic [SET_BITS-1:0] vic_set,
    output logic                vic_valid,
    output logic [1:0]          vic_way
);

    localparam int                  NUM_SETS = 2 ** SET_BITS;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [SET_BITS-1:0] ONE_IDX  = SET_BITS'(1);

    lru_state_e          state, state_nxt;
    logic [SET_BITS-1:0] init_idx, init_idx_nxt;

    lc3b_lru lru_array [NUM_SETS];

    logic                s1_valid;
    logic [SET_BITS-1:0] s1_set;
    lc3b_way             s1_way;
    lc3b_lru             s1_old;
    lc3b_lru             s1_new;

    logic    upd_hit;
    logic    upd_accept;
    logic    vic_accept;
    lc3b_lru upd_old;
    lc3b_lru vic_word;

    LRU_stack u_lru_stack (
        .way      (s1_way),
        .old_word (s1_old),
        .new_word (s1_new)
    );

    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        if (state == INIT) begin
            if (init_idx == LAST_SET) begin
                state_nxt = RUN;
            end else begin
                init_idx_nxt = init_idx + ONE_IDX;
            end
        end
    end

    always_comb begin
        upd_hit    = s1_valid && (s1_set == upd_set);
`ifdef LRU_BYPASS_EN
        upd_ready  = (state == RUN);
        upd_old    = upd_hit ? s1_new : lru_array[upd_set];
`else
        upd_ready  = (state == RUN) && !upd_hit;
        upd_old    = lru_array[upd_set];
`endif
        upd_accept = upd_req && upd_ready;
        vic_accept = vic_req && (state == RUN);
        // A stage-1 write landing on the request edge must be visible to the query.
        vic_word   = (s1_valid && (s1_set == vic_set)) ? s1_new : lru_array[vic_set];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_idx  <= '0;
            s1_valid  <= 1'b0;
            s1_set    <= '0;
            s1_way    <= '0;
            s1_old    <= '0;
            upd_ack   <= 1'b0;
            vic_valid <= 1'b0;
            vic_way   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            init_idx  <= init_idx_nxt;
            s1_valid  <= upd_accept;
            upd_ack   <= s1_valid;
            vic_valid <= vic_accept;
            if (upd_accept) begin
                s1_set <= upd_set;
                s1_way <= upd_way;
                s1_old <= upd_old;
            end
            if (vic_accept) begin
                vic_way <= vic_word[1:0];
            end
        end
    end

    // NOTE: the array has no reset; the INIT sweep writes every set before RUN is entered.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            lru_array[init_idx] <= LRU_INIT;
        end else if (s1_valid) begin
            lru_array[s1_set] <= s1_new;
        end
    end

endmodule

// File: tb/tb_lru_controller.sv
// Directed self-checking bench for lru_controller with SET_BITS=3 (8 sets).
module tb_lru_controller;

    localparam int SET_BITS = 3;
`ifdef LRU_BYPASS_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic                clk;
    logic                rst;
    logic                upd_req;
    logic [SET_BITS-1:0] upd_set;
    logic [1:0]          upd_way;
    logic                upd_ready;
    logic                upd_ack;
    logic                vic_req;
    logic [SET_BITS-1:0] vic_set;
    logic                vic_valid;
    logic [1:0]          vic_way;

    int checks    = 0;
    int errors    = 0;
    int ack_count = 0;

    lru_controller #(.SET_BITS(SET_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_req   (upd_req),
        .upd_set   (upd_set),
        .upd_way   (upd_way),
        .upd_ready (upd_ready),
        .upd_ack   (upd_ack),
        .vic_req   (vic_req),
        .vic_set   (vic_set),
        .vic_valid (vic_valid),
        .vic_way   (vic_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd_ack === 1'b1) ack_count++;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(input string tag);
        int n   = 0;
        bit bad = 1'b0;
        while (upd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
            if (vic_valid !== 1'b0 || upd_ack !== 1'b0) bad = 1'b1;
        end
        check({tag, " init cycles"}, n, 8);
        check({tag, " init quiet"}, 32'(bad), 0);
    endtask

    task automatic vic_query(input logic [SET_BITS-1:0] set, input string tag, input logic [1:0] exp_way);
        vic_req = 1'b1;
        vic_set = set;
        step();
        vic_req = 1'b0;
        check({tag, " valid"}, 32'(vic_valid), 1);
        check({tag, " way"}, 32'(vic_way), 32'(exp_way));
    endtask

    task automatic do_update(input logic [SET_BITS-1:0] set, input logic [1:0] way, input string tag);
        int a0;
        upd_req = 1'b1;
        upd_set = set;
        upd_way = way;
        #1;
        check({tag, " ready"}, 32'(upd_ready), 1);
        a0 = ack_count;
        step();
        upd_req = 1'b0;
        check({tag, " ack early"}, 32'(upd_ack), 0);
        step();
        check({tag, " ack"}, 32'(upd_ack), 1);
        step();
        check({tag, " ack drop"}, 32'(upd_ack), 0);
        check({tag, " ack count"}, ack_count - a0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int stalls;

        rst     = 1'b1;
        upd_req = 1'b0;
        upd_set = '0;
        upd_way = '0;
        vic_req = 1'b0;
        vic_set = '0;
        repeat (3) step();
        check("rst upd_ready", 32'(upd_ready), 0);
        check("rst upd_ack", 32'(upd_ack), 0);
        check("rst vic_valid", 32'(vic_valid), 0);
        check("rst vic_way", 32'(vic_way), 0);

        // Requests held through INIT must be ignored.
        upd_req = 1'b1;
        vic_req = 1'b1;
        vic_set = 3'd5;
        rst     = 1'b0;
        count_init("boot");
        upd_req = 1'b0;
        vic_req = 1'b0;

        vic_query(3'd5, "vic s5", 2'd0);
        step();
        check("vic pulse drop", 32'(vic_valid), 0);

        // E4 + way0 -> 39, LRU way 1
        do_update(3'd2, 2'd0, "upd s2w0");
        vic_query(3'd2, "vic s2", 2'd1);

        // Fresh set: way0 -> 39, then way1 -> 4E; a stale old word would give 78 (LRU 0).
        upd_req = 1'b1;
        upd_set = 3'd3;
        upd_way = 2'd0;
        #1;
        check("b2b first ready", 32'(upd_ready), 1);
        a0 = ack_count;
        step();
        upd_way = 2'd1;
        #1;
        stalls = 0;
        while (upd_ready !== 1'b1 && stalls < 10) begin
            step();
            stalls++;
        end
        check("b2b same-set stall", stalls, EXP_STALL);
        step();
        upd_req = 1'b0;
        repeat (3) step();
        check("b2b acks", ack_count - a0, 2);
        vic_query(3'd3, "vic s3", 2'd2);

        // Different sets back-to-back never stall.
        upd_req = 1'b1;
        upd_set = 3'd6;
        upd_way = 2'd0;
        #1;
        check("diff s6 ready", 32'(upd_ready), 1);
        a0 = ack_count;
        step();
        upd_set = 3'd7;
        #1;
        check("diff s7 ready", 32'(upd_ready), 1);
        step();
        upd_req = 1'b0;
        repeat (3) step();
        check("diff acks", ack_count - a0, 2);
        vic_query(3'd6, "vic s6", 2'd1);
        vic_query(3'd7, "vic s7", 2'd1);

        // MRU way: word unchanged, still acked.
        do_update(3'd4, 2'd3, "upd s4w3");
        vic_query(3'd4, "vic s4", 2'd0);

        // Same-edge update + query sees old word; query one cycle later sees stage-1 word.
        upd_req = 1'b1;
        upd_set = 3'd1;
        upd_way = 2'd0;
        vic_req = 1'b1;
        vic_set = 3'd1;
        #1;
        check("same-edge ready", 32'(upd_ready), 1);
        step();
        upd_req = 1'b0;
        check("same-edge vic valid", 32'(vic_valid), 1);
        check("same-edge vic way", 32'(vic_way), 0);
        step();
        vic_req = 1'b0;
        check("fwd vic valid", 32'(vic_valid), 1);
        check("fwd vic way", 32'(vic_way), 1);
        repeat (2) step();
        vic_query(3'd1, "vic s1 settled", 2'd1);

        // Reset between accept and write edge drops the update.
        repeat (2) step();
        a0 = ack_count;
        upd_req = 1'b1;
        upd_set = 3'd0;
        upd_way = 2'd0;
        step();
        upd_req = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("mid-upd rst ack", 32'(upd_ack), 0);
        check("mid-upd rst ready", 32'(upd_ready), 0);
        check("mid-upd ack count", ack_count - a0, 0);
        rst = 1'b0;
        count_init("post-rst");

        // Reset partway through INIT restarts the full sweep.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_init("mid-init");

        for (int s = 0; s < 8; s++) begin
            vic_query(SET_BITS'(s), $sformatf("reinit vic s%0d", s), 2'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lru_controller.md
LRU_CONTROLLER -- requirements
Module: lru_controller

Interface
REQ-001 SHALL have parameter SET_BITS, default 3, meaning log2 of the set count (NUM_SETS = 2**SET_BITS).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port upd_req, input, 1, meaning an access to update.
REQ-005 SHALL have port upd_set, input, SET_BITS, meaning the set being accessed.
REQ-006 SHALL have port upd_way, input, 2, meaning the way being accessed.
REQ-007 SHALL have port upd_ready, output, 1, meaning an update is accepted this cycle.
REQ-008 SHALL have port upd_ack, output, 1, a one-cycle pulse: update written.
REQ-009 SHALL have port vic_req, input, 1, meaning a victim query.
REQ-010 SHALL have port vic_set, input, SET_BITS, meaning the set being queried.
REQ-011 SHALL have port vic_valid, output, 1, meaning vic_way is valid.
REQ-012 SHALL have port vic_way, output, 2, meaning the least-recently-used way.

Function
REQ-013 SHALL hold one 8-bit LRU word per set: four 2-bit way IDs, MRU in [7:6], LRU in [1:0].
REQ-014 SHALL use states INIT and RUN; reset enters INIT with init_idx=0.
REQ-015 INIT SHALL write LRU_INIT (0xE4: order 3,2,1,0) to set init_idx each cycle and increment init_idx; after writing set NUM_SETS-1 it SHALL go to RUN on the next edge, taking NUM_SETS cycles in total.
REQ-016 upd_ready and vic acceptance SHALL be 0 in INIT; in INIT, vic_req and upd_req SHALL be ignored.
REQ-017 An update is accepted at the edge where upd_req&&upd_ready; that edge SHALL load stage 1 with set, way and the old LRU word.
REQ-018 At the following edge, the new word SHALL be written to the array; upd_ack SHALL be 1 for the cycle after that write edge (2-edge latency).
REQ-019 The new word SHALL be: way at [1:0] -> {way, old[7:2]}; way at [3:2] -> {way, old[7:4], old[1:0]}; way at [5:4] -> {way, old[7:6], old[3:0]}; way at [7:6] -> unchanged, still acked.
REQ-020 Back-to-back accepted updates SHALL sustain one per cycle when the sets differ.
REQ-021 A victim query in RUN SHALL always be accepted; vic_valid SHALL be 1 and vic_way = LRU[1:0] of vic_set in the cycle after the request edge.
REQ-022 The victim read SHALL include a stage-1 write to the same set pending at the request edge.
REQ-023 A victim query and an update accepted at the same edge to the same set SHALL return the pre-update value.
REQ-024 upd_set and vic_set indexes SHALL cover 0..NUM_SETS-1 with no aliasing; init_idx SHALL stop at NUM_SETS-1 and not wrap into RUN.

Reset
REQ-025 On rst, the block SHALL set state=INIT, init_idx=0, upd_ready=0, upd_ack=0, vic_valid=0, vic_way=0 and clear stage 1.
REQ-026 rst mid-INIT SHALL restart the sweep at set 0.
REQ-027 rst mid-update SHALL drop the pending write, with no ack.

Configuration
REQ-028 Macro LRU_BYPASS_EN defined: an update to the set held in stage 1 SHALL be accepted with stage 1's new word forwarded as its old word.
REQ-029 Macro LRU_BYPASS_EN undefined: upd_ready SHALL be 0 for the one cycle in which stage 1 is valid and upd_set equals the stage-1 set.

Structure
REQ-030 The package lc3b_types SHALL hold typedefs lc3b_lru (8-bit) and lc3b_way (2-bit) and the constant LRU_INIT=8'hE4.
REQ-031 The permutation of REQ-019 SHALL be one instance of the existing LRU_stack sub-module; array, FSM, pipeline and forwarding SHALL be in lru_controller.

Verification
REQ-032 With SET_BITS=3, release rst -> upd_ready rises after 8 cycles; vic_req set 5 -> vic_way=0.
REQ-033 Update set 2 way 0 -> upd_ack 2 edges later; word 0x39; vic set 2 -> vic_way=1.
REQ-034 Consecutive updates set 2 way 0 then way 1 -> word 0x4E, vic_way=2. With the macro, no stall; without it, upd_ready=0 for exactly 1 cycle.
REQ-035 Update fresh set 4 way 3 -> word stays 0xE4, upd_ack still pulses; vic_way=0.
REQ-036 Same-edge update set 1 way 0 plus vic set 1 -> vic_way=0; a vic one cycle later -> vic_way=1.
REQ-037 rst asserted between accept and write edge -> no upd_ack; 8-cycle INIT repeats; all sets read vic_way=0.
